// File: rtl/led_drv_pkg.sv
// Shared types for the LED pulse driver: FSM state encoding, MODE codes and
// a compile-time helper for sizing the stretch/gap down-counter.
package led_drv_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLit,
    StGap,
    StBlinkOn,
    StBlinkOff
  } led_state_e;

  localparam logic [1:0] MODE_OFF   = 2'b00;
  localparam logic [1:0] MODE_ON    = 2'b01;
  localparam logic [1:0] MODE_ACT   = 2'b10;
  localparam logic [1:0] MODE_BLINK = 2'b11;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/led_pwm.sv
// Free-running PWM counter with a duty compare; on-fraction is duty / 2^PWM_W.
module led_pwm #(
  parameter int unsigned PWM_W = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [PWM_W-1:0] i_duty,
  output logic             o_pwm_on
);

  logic [PWM_W-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + PWM_W'(1);
    end
  end

  assign o_pwm_on = (r_cnt < i_duty);

endmodule

// File: rtl/led_pulse_driver.sv
// Activity LED driver: stretches EVENT strobes into visible pulses with a
// forced-off gap, plus ON/OFF/BLINK modes, all dimmed by a PWM stage.
module led_pulse_driver
  import led_drv_pkg::*;
#(
  parameter int unsigned STRETCH_CYCLES = 1000000,
  parameter int unsigned GAP_CYCLES     = 250000,
  parameter int unsigned PWM_W          = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             EVENT,
  input  logic [1:0]       MODE,
  input  logic [PWM_W-1:0] DUTY,
  output logic             A,
  output logic             BUSY
);

  localparam int unsigned CNT_W = $clog2(max_u(STRETCH_CYCLES, GAP_CYCLES) + 1);
  localparam logic [CNT_W-1:0] STRETCH_LOAD = CNT_W'(STRETCH_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD     = CNT_W'(GAP_CYCLES - 1);

  led_state_e       r_state, w_state_d;
  logic [CNT_W-1:0] r_cnt, w_cnt_d;
  logic             r_pend, w_pend_d;
  logic [1:0]       r_mode;
  logic             r_a;
  logic             w_lit;
  logic             w_pwm_on;
  logic             w_cnt_zero;

  led_pwm #(
    .PWM_W (PWM_W)
  ) u_pwm (
    .i_clk    (CLK),
    .i_rst    (RST),
    .i_duty   (DUTY),
    .o_pwm_on (w_pwm_on)
  );

  assign w_cnt_zero = (r_cnt == '0);

  always_comb begin
    w_state_d = r_state;
    w_cnt_d   = r_cnt;
    w_pend_d  = r_pend;
    // A mode change aborts whatever is in flight; the new mode starts from IDLE.
    if (MODE != r_mode) begin
      w_state_d = StIdle;
      w_cnt_d   = '0;
      w_pend_d  = 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (MODE == MODE_ACT && EVENT) begin
            w_state_d = StLit;
            w_cnt_d   = STRETCH_LOAD;
            w_pend_d  = 1'b0;
          end else if (MODE == MODE_BLINK) begin
            w_state_d = StBlinkOn;
            w_cnt_d   = STRETCH_LOAD;
          end
        end
        StLit: begin
          if (EVENT) begin
            w_cnt_d = STRETCH_LOAD;
          end else if (w_cnt_zero) begin
            w_state_d = StGap;
            w_cnt_d   = GAP_LOAD;
          end else begin
            w_cnt_d = r_cnt - CNT_W'(1);
          end
        end
        StGap: begin
          if (w_cnt_zero) begin
            w_pend_d = 1'b0;
            if (r_pend || EVENT) begin
              w_state_d = StLit;
              w_cnt_d   = STRETCH_LOAD;
            end else begin
              w_state_d = StIdle;
            end
          end else begin
            w_cnt_d  = r_cnt - CNT_W'(1);
            w_pend_d = r_pend | EVENT;
          end
        end
        StBlinkOn, StBlinkOff: begin
          if (w_cnt_zero) begin
            w_state_d = (r_state == StBlinkOn) ? StBlinkOff : StBlinkOn;
            w_cnt_d   = STRETCH_LOAD;
          end else begin
            w_cnt_d = r_cnt - CNT_W'(1);
          end
        end
        default: begin
          w_state_d = StIdle;
          w_cnt_d   = '0;
          w_pend_d  = 1'b0;
        end
      endcase
    end
  end

  assign w_lit = (r_state == StLit) || (r_state == StBlinkOn) || (MODE == MODE_ON);

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= StIdle;
      r_cnt   <= '0;
      r_pend  <= 1'b0;
      r_mode  <= MODE_OFF;
      r_a     <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_cnt   <= w_cnt_d;
      r_pend  <= w_pend_d;
      r_mode  <= MODE;
      r_a     <= w_lit & w_pwm_on;
    end
  end

  assign A    = r_a;
  assign BUSY = (r_state == StLit) || (r_state == StGap);

endmodule

// File: tb/tb_led_pulse_driver.sv
// Scoreboard bench for led_pulse_driver: a cycle model built on remaining-time
// counts predicts A/BUSY per edge; a monitor compares one cycle later.
module tb_led_pulse_driver;

  localparam int S  = 8;
  localparam int G  = 4;
  localparam int PW = 2;

  localparam logic [1:0] M_OFF = 2'b00;
  localparam logic [1:0] M_ON  = 2'b01;
  localparam logic [1:0] M_ACT = 2'b10;
  localparam logic [1:0] M_BLK = 2'b11;

  logic          CLK   = 1'b0;
  logic          RST   = 1'b1;
  logic          EVENT = 1'b0;
  logic [1:0]    MODE  = 2'b00;
  logic [PW-1:0] DUTY  = 2'd3;
  logic          A;
  logic          BUSY;

  always #5 CLK = ~CLK;

  led_pulse_driver #(
    .STRETCH_CYCLES (S),
    .GAP_CYCLES     (G),
    .PWM_W          (PW)
  ) dut (
    .CLK   (CLK),
    .RST   (RST),
    .EVENT (EVENT),
    .MODE  (MODE),
    .DUTY  (DUTY),
    .A     (A),
    .BUSY  (BUSY)
  );

  typedef struct {
    logic a;
    logic busy;
    int   cyc;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  // Model: cycles of lit time left, cycles of gap left, age within blinking.
  int         m_lit   = 0;
  int         m_gap   = 0;
  int         m_blink = -1;
  bit         m_pend  = 1'b0;
  logic [1:0] m_mode  = 2'b00;
  int         m_pwm   = 0;

  task automatic step(input bit rst, input bit ev, input logic [1:0] mode,
                      input logic [PW-1:0] duty);
    bit   lit_now;
    bit   exp_a;
    exp_t e;
    @(negedge CLK);
    RST   = rst;
    EVENT = ev;
    MODE  = mode;
    DUTY  = duty;
    cyc++;
    lit_now = (m_lit > 0) || (m_blink >= 0 && ((m_blink / S) % 2 == 0)) || (mode == M_ON);
    exp_a   = !rst && lit_now && (m_pwm < int'(duty));
    if (rst) begin
      m_lit = 0; m_gap = 0; m_blink = -1; m_pend = 0; m_mode = M_OFF; m_pwm = 0;
    end else begin
      m_pwm = (m_pwm + 1) % (1 << PW);
      if (mode != m_mode) begin
        m_lit = 0; m_gap = 0; m_blink = -1; m_pend = 0;
      end else if (mode == M_ACT) begin
        if (m_lit > 0) begin
          if (ev) m_lit = S;
          else if (m_lit == 1) begin m_lit = 0; m_gap = G; end
          else m_lit--;
        end else if (m_gap > 0) begin
          m_pend = m_pend | ev;
          if (m_gap == 1) begin
            m_gap = 0;
            if (m_pend) m_lit = S;
            m_pend = 0;
          end else m_gap--;
        end else if (ev) begin
          m_lit = S;
        end
      end else if (mode == M_BLK) begin
        m_blink = (m_blink < 0) ? 0 : (m_blink + 1) % (2 * S);
      end
      m_mode = mode;
    end
    e.a    = exp_a;
    e.busy = (m_lit > 0) || (m_gap > 0);
    e.cyc  = cyc;
    q.push_back(e);
  endtask

  task automatic act_run(input int len, input int e1, input int e2);
    for (int i = 0; i < len; i++) step(1'b0, (i == e1) || (i == e2), M_ACT, 2'd3);
  endtask

  // Monitor: every cycle the DUT presents A/BUSY; compare against the queue head.
  initial begin
    exp_t e;
    forever begin
      @(posedge CLK);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        checks++;
        if (A !== e.a) begin
          errors++;
          $display("FAIL A cyc=%0d got %b expected %b", e.cyc, A, e.a);
        end
        checks++;
        if (BUSY !== e.busy) begin
          errors++;
          $display("FAIL BUSY cyc=%0d got %b expected %b", e.cyc, BUSY, e.busy);
        end
      end
    end
  end

  initial begin
    logic [1:0]    rmode;
    logic [PW-1:0] rduty;
    repeat (3) step(1'b1, 1'b1, M_ACT, 2'd3);
    // Single event, two events in LIT, event during GAP.
    act_run(30, 10, -1);
    act_run(35, 10, 15);
    act_run(45, 10, 20);
    // Reset mid-LIT with EVENT high, then a fresh event.
    for (int i = 0; i < 40; i++) step(i == 14, (i == 10) || (i == 14) || (i == 25), M_ACT, 2'd3);
    // ACTIVITY -> ON mid-LIT.
    for (int i = 0; i < 30; i++) step(1'b0, i == 10, (i >= 12) ? M_ON : M_ACT, 2'd3);
    // BLINK dark then bright; OFF ignores events.
    for (int i = 0; i < 40; i++) step(1'b0, i % 3 == 0, M_BLK, 2'd0);
    for (int i = 0; i < 40; i++) step(1'b0, i % 3 == 0, M_BLK, 2'd3);
    for (int i = 0; i < 20; i++) step(1'b0, i % 2 == 0, M_OFF, 2'd3);
    // Randomized traffic.
    rmode = M_ACT;
    rduty = 2'd3;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(199) == 0) rmode = 2'($urandom_range(3));
      if ($urandom_range(49) == 0)  rduty = PW'($urandom_range(3));
      step($urandom_range(499) == 0, $urandom_range(9) == 0, rmode, rduty);
    end
    repeat (3) @(negedge CLK);
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d expected 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/led_pulse_driver.md
LED_PULSE_DRIVER -- requirements
Module: led_pulse_driver

Interface
REQ-001 SHALL have parameter STRETCH_CYCLES, default 1000000: LED on-time per event, and blink half-period, in CLK cycles (>=2).
REQ-002 SHALL have parameter GAP_CYCLES, default 250000: forced-off time after each stretch, in CLK cycles (>=1).
REQ-003 SHALL have parameter PWM_W, default 4: brightness resolution in bits.
REQ-004 SHALL have port CLK, input, 1 bit: the single clock; all state changes on the rising edge.
REQ-005 SHALL have port RST, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have port EVENT, input, 1 bit: activity strobe, level-sampled each cycle.
REQ-007 SHALL have port MODE, input, 2 bits: 00 OFF, 01 ON, 10 ACTIVITY, 11 BLINK.
REQ-008 SHALL have port DUTY, input, PWM_W bits: brightness, on-fraction DUTY/2^PWM_W.
REQ-009 SHALL have port A, output, 1 bit: registered LED drive, feeding the LED anode node of the decap/LED cell.
REQ-010 SHALL have port BUSY, output, 1 bit: high while the FSM is in LIT or GAP.

Function
REQ-011 SHALL implement FSM states IDLE, LIT, GAP, BLINK_ON, BLINK_OFF with one down-counter sized ceil(log2(max(STRETCH_CYCLES,GAP_CYCLES)+1)).
REQ-012 ACTIVITY mode: IDLE with EVENT=1 -> LIT, counter loads STRETCH_CYCLES-1.
REQ-013 LIT: counter decrements each cycle; EVENT=1 in LIT reloads STRETCH_CYCLES-1 (retrigger); at counter 0 with no EVENT -> GAP, counter loads GAP_CYCLES-1.
REQ-014 GAP: EVENT=1 sets a pending flag; at counter 0 -> LIT (reload, clear pending) if pending or EVENT, else IDLE.
REQ-015 BLINK mode: IDLE -> BLINK_ON; BLINK_ON/BLINK_OFF alternate every STRETCH_CYCLES cycles; EVENT ignored.
REQ-016 ON mode: lit constantly; OFF mode: never lit; FSM held in IDLE in both; EVENT ignored.
REQ-017 Any MODE change (MODE differs from previous-cycle registered value): next state IDLE, counter 0, pending cleared; new mode acts from the following cycle.
REQ-018 PWM: free-running PWM_W-bit counter, wraps 2^PWM_W-1 -> 0; pwm_on = (pwm_cnt < DUTY); DUTY=0 gives always off; DUTY all-ones gives (2^PWM_W-1)/2^PWM_W.
REQ-019 A SHALL equal, one cycle late, lit AND pwm_on, where lit = state in {LIT, BLINK_ON} or MODE=ON; EVENT sampled at edge k gives A=1 after edge k+1 (2-cycle latency).
REQ-020 BUSY SHALL be combinational from the state register (0-cycle latency relative to state).
REQ-021 DUTY and MODE sampled every cycle; no handshake; DUTY changes take effect on the next PWM comparison.

Reset
REQ-022 RST=1 at an edge: state IDLE, counter 0, pending 0, pwm_cnt 0, registered MODE 00, A 0, BUSY 0, regardless of prior state (including mid-LIT/GAP).
REQ-023 EVENT asserted during RST SHALL be discarded; first accepted EVENT is at the first edge with RST=0.

Structure
REQ-024 Package led_drv_pkg SHALL hold the state enum and MODE encodings (MODE_OFF, MODE_ON, MODE_ACT, MODE_BLINK).
REQ-025 Sub-module led_pwm (PWM counter + compare, outputs pwm_on) SHALL be the only child; FSM and stretch counter live in the top.

Verification (STRETCH_CYCLES=8, GAP_CYCLES=4, PWM_W=2, DUTY=3 unless noted)
REQ-026 ACTIVITY, single EVENT at cycle 10 -> BUSY 11..22 (LIT 11..18, GAP 19..22); A follows lit delayed 1 cycle, pulsed 3 of every 4 cycles.
REQ-027 EVENT at 10 and 15 -> LIT extends to cycle 23, GAP 24..27, then IDLE.
REQ-028 EVENT at 10, EVENT during GAP at 20 -> LIT re-entered at cycle 23 for 8 cycles; no EVENT lost.
REQ-029 BLINK, DUTY=0 -> A stays 0 throughout; DUTY=3 -> lit alternates every 8 cycles, BUSY stays 0.
REQ-030 RST asserted at cycle 14 mid-LIT with EVENT=1 -> cycle 15: A=0, BUSY=0, state IDLE; resumes only on a new EVENT after RST drops.
REQ-031 MODE switch ACTIVITY->ON at cycle 12 mid-LIT -> IDLE at 13, A at PWM duty from 14, BUSY 0 from 13.
